cr_tcipif_ibus_arb: RTL and testbench

//  Arbitrates two masters (IFU fetch, LSU/debug) onto the single TCIP ibus slave port.
//  One outstanding transaction at a time: latches the winner as owner and routes responses only to it.
//  LSU has fixed priority, with an anti-starvation counter for IFU and a completion timeout.

---
 rtl/cr_tcipif_ibus_arb_pkg.sv | 20 ++
 rtl/cr_tcipif_arb_timer.sv | 47 ++++
 rtl/cr_tcipif_ibus_arb.sv | 165 ++++++++++++++++
 tb/tb_cr_tcipif_ibus_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cr_tcipif_ibus_arb_pkg.sv
// ---------------------------------------------------------------------------
// cr_tcipif_ibus_arb_pkg : shared state and owner encodings for the ibus arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cr_tcipif_ibus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_BUSY   = 2'b01,
      ST_ERRRSP = 2'b10
   } arb_state_e;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cr_tcipif_arb_timer.sv
// ---------------------------------------------------------------------------
// cr_tcipif_arb_timer : BUSY-cycle counter raising expiry on the last cycle
// before an error response is due. Tied inactive when TIMEOUT is 0.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cr_tcipif_arb_timer #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   generate
      if (TIMEOUT == 0) begin : g_tmo_off
         logic w_unused_ok;
         assign w_unused_ok = ^{clk, rst, i_clr, i_en};
         assign o_expire    = 1'b0;
      end else begin : g_tmo_on
         localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
         localparam logic [CW:0] c_LIM = (CW + 1)'(TIMEOUT - 1);

         logic [CW-1:0] r_cnt;
         logic [CW:0]   w_cnt_inc;

         // Expire when the incremented count reaches TIMEOUT-1, so the error
         // response lands exactly TIMEOUT cycles after the grant cycle.
         assign w_cnt_inc = {1'b0, r_cnt} + (CW + 1)'(1);
         assign o_expire  = i_en && (w_cnt_inc >= c_LIM);

         always_ff @(posedge clk) begin
            if (rst || i_clr) begin
               r_cnt <= '0;
            end else if (i_en) begin
               r_cnt <= w_cnt_inc[CW-1:0];
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/cr_tcipif_ibus_arb.sv
// ---------------------------------------------------------------------------
// cr_tcipif_ibus_arb : IFU/LSU arbiter onto the single TCIP ibus slave port,
// one outstanding transaction, LSU priority with IFU anti-starvation.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cr_tcipif_ibus_arb
   import cr_tcipif_ibus_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned STARV_MAX = 4,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   input  logic              ifu_arb_req,
   input  logic [ADDR_W-1:0] ifu_arb_addr,
   input  logic              ifu_arb_write,
   input  logic              ifu_arb_acc_deny,
   input  logic              lsu_arb_req,
   input  logic [ADDR_W-1:0] lsu_arb_addr,
   input  logic              lsu_arb_write,
   input  logic              lsu_arb_acc_deny,
   output logic              arb_ifu_grnt,
   output logic [DATA_W-1:0] arb_ifu_data,
   output logic              arb_ifu_data_vld,
   output logic              arb_ifu_acc_err,
   output logic              arb_ifu_trans_cmplt,
   output logic              arb_lsu_grnt,
   output logic [DATA_W-1:0] arb_lsu_data,
   output logic              arb_lsu_data_vld,
   output logic              arb_lsu_acc_err,
   output logic              arb_lsu_trans_cmplt,
   output logic              arb_tcipif_ibus_req,
   output logic [ADDR_W-1:0] arb_tcipif_ibus_addr,
   output logic              arb_tcipif_ibus_write,
   output logic              arb_tcipif_ibus_acc_deny,
   input  logic              tcipif_arb_ibus_grnt,
   input  logic [DATA_W-1:0] tcipif_arb_ibus_data,
   input  logic              tcipif_arb_ibus_data_vld,
   input  logic              tcipif_arb_ibus_acc_err,
   input  logic              tcipif_arb_ibus_trans_cmplt
);

   localparam int unsigned SW = $clog2(STARV_MAX + 1);
   localparam logic [SW-1:0] c_STARV_MAX = SW'(STARV_MAX);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic              r_owner;
   logic [SW-1:0]     r_starv;

   logic              w_idle;
   logic              w_lsu_win;
   logic              w_ifu_win;
   logic              w_dn_req;
   logic              w_hs;
   logic              w_tmo_en;
   logic              w_tmo_exp;
   logic [DATA_W-1:0] w_rsp_data;
   logic              w_rsp_vld;
   logic              w_rsp_err;
   logic              w_rsp_cmplt;

   assign w_idle    = (r_state == ST_IDLE);
   // A pending IFU that has lost STARV_MAX times in a row overrides LSU priority.
   assign w_lsu_win = lsu_arb_req && !(ifu_arb_req && (r_starv == c_STARV_MAX));
   assign w_ifu_win = ifu_arb_req && !w_lsu_win;
   assign w_dn_req  = w_idle && (w_lsu_win || w_ifu_win);
   assign w_hs      = w_dn_req && tcipif_arb_ibus_grnt;

   assign arb_tcipif_ibus_req      = w_dn_req;
   assign arb_tcipif_ibus_addr     = !w_dn_req ? '0   : (w_lsu_win ? lsu_arb_addr     : ifu_arb_addr);
   assign arb_tcipif_ibus_write    = !w_dn_req ? 1'b0 : (w_lsu_win ? lsu_arb_write    : ifu_arb_write);
   assign arb_tcipif_ibus_acc_deny = !w_dn_req ? 1'b0 : (w_lsu_win ? lsu_arb_acc_deny : ifu_arb_acc_deny);

   assign arb_ifu_grnt = w_dn_req && w_ifu_win && tcipif_arb_ibus_grnt;
   assign arb_lsu_grnt = w_dn_req && w_lsu_win && tcipif_arb_ibus_grnt;

   assign w_tmo_en = (r_state == ST_BUSY) && !tcipif_arb_ibus_trans_cmplt;

   cr_tcipif_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (forever_cpuclk),
      .rst      (cpurst),
      .i_clr    (w_hs),
      .i_en     (w_tmo_en),
      .o_expire (w_tmo_exp)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_rsp_data  = '0;
      w_rsp_vld   = 1'b0;
      w_rsp_err   = 1'b0;
      w_rsp_cmplt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_hs) begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_rsp_data  = tcipif_arb_ibus_data;
            w_rsp_vld   = tcipif_arb_ibus_data_vld;
            w_rsp_err   = tcipif_arb_ibus_acc_err;
            w_rsp_cmplt = tcipif_arb_ibus_trans_cmplt;
            if (tcipif_arb_ibus_trans_cmplt) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tmo_exp) begin
               w_state_nxt = ST_ERRRSP;
            end
         end
         ST_ERRRSP: begin
            w_rsp_err   = 1'b1;
            w_rsp_cmplt = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_IFU;
      end else begin
         r_state <= w_state_nxt;
         if (w_hs) begin
            r_owner <= w_lsu_win ? OWN_LSU : OWN_IFU;
         end
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_starv <= '0;
      end else if (w_idle) begin
         if (!ifu_arb_req || (w_hs && w_ifu_win)) begin
            r_starv <= '0;
         end else if (w_hs && w_lsu_win && (r_starv != c_STARV_MAX)) begin
            r_starv <= r_starv + SW'(1);
         end
      end
   end

   // Outside BUSY/ERRRSP the response bus is already zero, so late slave
   // responses never reach either master.
   assign arb_ifu_data        = (r_owner == OWN_IFU) ? w_rsp_data  : '0;
   assign arb_ifu_data_vld    = (r_owner == OWN_IFU) && w_rsp_vld;
   assign arb_ifu_acc_err     = (r_owner == OWN_IFU) && w_rsp_err;
   assign arb_ifu_trans_cmplt = (r_owner == OWN_IFU) && w_rsp_cmplt;
   assign arb_lsu_data        = (r_owner == OWN_LSU) ? w_rsp_data  : '0;
   assign arb_lsu_data_vld    = (r_owner == OWN_LSU) && w_rsp_vld;
   assign arb_lsu_acc_err     = (r_owner == OWN_LSU) && w_rsp_err;
   assign arb_lsu_trans_cmplt = (r_owner == OWN_LSU) && w_rsp_cmplt;

endmodule

`default_nettype wire

// File: tb/tb_cr_tcipif_ibus_arb.sv
// ---------------------------------------------------------------------------
// tb_cr_tcipif_ibus_arb : random master/slave traffic against a transaction-
// level model of ownership, starvation streak and timeout age.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cr_tcipif_ibus_arb;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;
   localparam int TMO  = 8;
   localparam int NCYC = 4000;

   logic          clk = 1'b0;
   logic          cpurst;
   logic          ifu_arb_req, ifu_arb_write, ifu_arb_acc_deny;
   logic [AW-1:0] ifu_arb_addr;
   logic          lsu_arb_req, lsu_arb_write, lsu_arb_acc_deny;
   logic [AW-1:0] lsu_arb_addr;
   logic          arb_ifu_grnt, arb_ifu_data_vld, arb_ifu_acc_err, arb_ifu_trans_cmplt;
   logic [DW-1:0] arb_ifu_data;
   logic          arb_lsu_grnt, arb_lsu_data_vld, arb_lsu_acc_err, arb_lsu_trans_cmplt;
   logic [DW-1:0] arb_lsu_data;
   logic          arb_tcipif_ibus_req, arb_tcipif_ibus_write, arb_tcipif_ibus_acc_deny;
   logic [AW-1:0] arb_tcipif_ibus_addr;
   logic          tcipif_arb_ibus_grnt, tcipif_arb_ibus_data_vld;
   logic          tcipif_arb_ibus_acc_err, tcipif_arb_ibus_trans_cmplt;
   logic [DW-1:0] tcipif_arb_ibus_data;

   int n_cmp = 0;
   int n_mis = 0;

   // Model: phase 0=no transaction, 1=outstanding, 2=error response due.
   int m_phase  = 0;
   int m_owner  = 0;  // 0 = IFU, 1 = LSU
   int m_age    = 0;  // cycles the outstanding transaction has waited
   int m_streak = 0;  // LSU wins in a row while IFU was waiting

   always #5 clk = ~clk;

   cr_tcipif_ibus_arb #(
      .ADDR_W(AW), .DATA_W(DW), .STARV_MAX(SMAX), .TIMEOUT(TMO)
   ) dut (
      .forever_cpuclk              (clk),
      .cpurst                      (cpurst),
      .ifu_arb_req                 (ifu_arb_req),
      .ifu_arb_addr                (ifu_arb_addr),
      .ifu_arb_write               (ifu_arb_write),
      .ifu_arb_acc_deny            (ifu_arb_acc_deny),
      .lsu_arb_req                 (lsu_arb_req),
      .lsu_arb_addr                (lsu_arb_addr),
      .lsu_arb_write               (lsu_arb_write),
      .lsu_arb_acc_deny            (lsu_arb_acc_deny),
      .arb_ifu_grnt                (arb_ifu_grnt),
      .arb_ifu_data                (arb_ifu_data),
      .arb_ifu_data_vld            (arb_ifu_data_vld),
      .arb_ifu_acc_err             (arb_ifu_acc_err),
      .arb_ifu_trans_cmplt         (arb_ifu_trans_cmplt),
      .arb_lsu_grnt                (arb_lsu_grnt),
      .arb_lsu_data                (arb_lsu_data),
      .arb_lsu_data_vld            (arb_lsu_data_vld),
      .arb_lsu_acc_err             (arb_lsu_acc_err),
      .arb_lsu_trans_cmplt         (arb_lsu_trans_cmplt),
      .arb_tcipif_ibus_req         (arb_tcipif_ibus_req),
      .arb_tcipif_ibus_addr        (arb_tcipif_ibus_addr),
      .arb_tcipif_ibus_write       (arb_tcipif_ibus_write),
      .arb_tcipif_ibus_acc_deny    (arb_tcipif_ibus_acc_deny),
      .tcipif_arb_ibus_grnt        (tcipif_arb_ibus_grnt),
      .tcipif_arb_ibus_data        (tcipif_arb_ibus_data),
      .tcipif_arb_ibus_data_vld    (tcipif_arb_ibus_data_vld),
      .tcipif_arb_ibus_acc_err     (tcipif_arb_ibus_acc_err),
      .tcipif_arb_ibus_trans_cmplt (tcipif_arb_ibus_trans_cmplt)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit lsu_wins();
      return (m_phase == 0) && lsu_arb_req && !(ifu_arb_req && (m_streak == SMAX));
   endfunction

   function automatic bit ifu_wins();
      return (m_phase == 0) && ifu_arb_req && !lsu_wins();
   endfunction

   task automatic check_outputs();
      logic [DW+2:0] slv, e_ifu, e_lsu, ob_ifu, ob_lsu;
      bit lw, iw;
      lw  = lsu_wins();
      iw  = ifu_wins();
      slv = {tcipif_arb_ibus_data, tcipif_arb_ibus_data_vld,
             tcipif_arb_ibus_acc_err, tcipif_arb_ibus_trans_cmplt};
      e_ifu = '0;
      e_lsu = '0;
      if (m_phase == 1) begin
         if (m_owner == 1) e_lsu = slv; else e_ifu = slv;
      end else if (m_phase == 2) begin
         if (m_owner == 1) e_lsu = {{DW{1'b0}}, 3'b011}; else e_ifu = {{DW{1'b0}}, 3'b011};
      end
      ob_ifu = {arb_ifu_data, arb_ifu_data_vld, arb_ifu_acc_err, arb_ifu_trans_cmplt};
      ob_lsu = {arb_lsu_data, arb_lsu_data_vld, arb_lsu_acc_err, arb_lsu_trans_cmplt};
      check_val("ifu_grnt", 64'(arb_ifu_grnt), 64'(iw && tcipif_arb_ibus_grnt));
      check_val("lsu_grnt", 64'(arb_lsu_grnt), 64'(lw && tcipif_arb_ibus_grnt));
      check_val("dn_req",   64'(arb_tcipif_ibus_req), 64'(lw || iw));
      if (lw || iw) begin
         check_val("dn_addr",  64'(arb_tcipif_ibus_addr),
                   64'(lw ? lsu_arb_addr : ifu_arb_addr));
         check_val("dn_wr_deny", 64'({arb_tcipif_ibus_write, arb_tcipif_ibus_acc_deny}),
                   64'(lw ? {lsu_arb_write, lsu_arb_acc_deny} : {ifu_arb_write, ifu_arb_acc_deny}));
      end
      check_val("ifu_rsp", 64'(ob_ifu), 64'(e_ifu));
      check_val("lsu_rsp", 64'(ob_lsu), 64'(e_lsu));
   endtask

   task automatic model_step();
      bit lw, iw, hs;
      lw = lsu_wins();
      iw = ifu_wins();
      hs = (lw || iw) && tcipif_arb_ibus_grnt;
      if (cpurst) begin
         m_phase  = 0;
         m_owner  = 0;
         m_streak = 0;
      end else if (m_phase == 0) begin
         if (!ifu_arb_req || (hs && iw)) m_streak = 0;
         else if (hs && lw && m_streak < SMAX) m_streak++;
         if (hs) begin
            m_phase = 1;
            m_owner = lw ? 1 : 0;
            m_age   = 0;
         end
      end else if (m_phase == 1) begin
         m_age++;
         if (tcipif_arb_ibus_trans_cmplt) m_phase = 0;
         else if (m_age == TMO - 1)       m_phase = 2;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic drive_random();
      cpurst           = ($urandom_range(249) == 0);
      ifu_arb_req      = ($urandom_range(3) != 0);
      lsu_arb_req      = ($urandom_range(3) != 0);
      ifu_arb_addr     = $urandom;
      lsu_arb_addr     = $urandom;
      ifu_arb_write    = $urandom_range(1) == 1;
      lsu_arb_write    = $urandom_range(1) == 1;
      ifu_arb_acc_deny = $urandom_range(7) == 0;
      lsu_arb_acc_deny = $urandom_range(7) == 0;
      tcipif_arb_ibus_grnt        = ($urandom_range(3) != 0);
      tcipif_arb_ibus_data        = $urandom;
      tcipif_arb_ibus_data_vld    = $urandom_range(1) == 1;
      tcipif_arb_ibus_acc_err     = $urandom_range(5) == 0;
      tcipif_arb_ibus_trans_cmplt = ($urandom_range(5) == 0);
   endtask

   initial begin
      cpurst = 1'b1;
      ifu_arb_req = 1'b0; ifu_arb_addr = '0; ifu_arb_write = 1'b0; ifu_arb_acc_deny = 1'b0;
      lsu_arb_req = 1'b0; lsu_arb_addr = '0; lsu_arb_write = 1'b0; lsu_arb_acc_deny = 1'b0;
      tcipif_arb_ibus_grnt = 1'b0; tcipif_arb_ibus_data = '0; tcipif_arb_ibus_data_vld = 1'b0;
      tcipif_arb_ibus_acc_err = 1'b0; tcipif_arb_ibus_trans_cmplt = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cpurst = 1'b0;
      #1;
      check_val("rst_dn_req",   64'(arb_tcipif_ibus_req), 64'd0);
      check_val("rst_grnts",    64'({arb_ifu_grnt, arb_lsu_grnt}), 64'd0);
      check_val("rst_ifu_outs", 64'({arb_ifu_data, arb_ifu_data_vld, arb_ifu_acc_err, arb_ifu_trans_cmplt}), 64'd0);
      check_val("rst_lsu_outs", 64'({arb_lsu_data, arb_lsu_data_vld, arb_lsu_acc_err, arb_lsu_trans_cmplt}), 64'd0);
      @(posedge clk);
      model_step();

      for (int i = 0; i < NCYC; i++) begin
         @(negedge clk);
         drive_random();
         #1;
         check_outputs();
         @(posedge clk);
         model_step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
